// File: rtl/reg_wr_arbiter.sv
// Register-file write arbiter.
// Clears every register to zero after reset (or on clr_start), then
// round-robins single-cycle write requests from three requesters into one
// registered write port. Out-of-range addresses are consumed and flagged.
module reg_wr_arbiter #(
    parameter int PW = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [2:0]            req_valid,
    input  logic [3*(PW+1)-1:0]   req_addr,
    input  logic [23:0]           req_data,
    output logic [2:0]            req_ready,
    input  logic                  clr_start,
    output logic                  wr_en,
    output logic [PW:0]           wr_addr,
    output logic [7:0]            wr_data,
    output logic                  init_busy,
    output logic                  err_oob
);

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Last register index; the clear write for it hands over to RUN.
    localparam logic [PW-1:0] CNT_LAST = {PW{1'b1}};

    state_t          state_q, state_d;
    logic [PW-1:0]   cnt_q, cnt_d;
    logic [1:0]      ptr_q, ptr_d;
    logic            wr_en_q, wr_en_d;
    logic [PW:0]     wr_addr_q, wr_addr_d;
    logic [7:0]      wr_data_q, wr_data_d;
    logic            err_oob_q, err_oob_d;

    logic [2:0]      grant;
    logic [PW:0]     sel_addr;
    logic [7:0]      sel_data;
    logic [PW-1:0]   cnt_eff;

    // Round-robin grant: first valid requester at or after ptr, modulo 3.
    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no path leaves it unassigned and no latch is inferred.
        grant = 3'b000;
        if (state_q == RUN && !clr_start) begin
            case (ptr_q)
                2'd1: begin
                    if      (req_valid[1]) grant = 3'b010;
                    else if (req_valid[2]) grant = 3'b100;
                    else if (req_valid[0]) grant = 3'b001;
                end
                2'd2: begin
                    if      (req_valid[2]) grant = 3'b100;
                    else if (req_valid[0]) grant = 3'b001;
                    else if (req_valid[1]) grant = 3'b010;
                end
                default: begin
                    if      (req_valid[0]) grant = 3'b001;
                    else if (req_valid[1]) grant = 3'b010;
                    else if (req_valid[2]) grant = 3'b100;
                end
            endcase
        end
    end

    // Route the granted requester's address and data to the write path.
    always_comb begin
        sel_addr = req_addr[0 +: PW+1];
        sel_data = req_data[0 +: 8];
        case (grant)
            3'b010: begin
                sel_addr = req_addr[(PW+1) +: PW+1];
                sel_data = req_data[8 +: 8];
            end
            3'b100: begin
                sel_addr = req_addr[2*(PW+1) +: PW+1];
                sel_data = req_data[16 +: 8];
            end
            default: ;
        endcase
    end

    // Next-state logic: clear sweep in INIT, grant-driven writes in RUN.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        ptr_d     = ptr_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        err_oob_d = 1'b0;
        cnt_eff   = cnt_q;

        case (state_q)
            INIT: begin
                // clr_start mid-sweep restarts it, issuing address 0 now.
                cnt_eff   = clr_start ? '0 : cnt_q;
                wr_en_d   = 1'b1;
                wr_addr_d = {1'b0, cnt_eff};
                wr_data_d = 8'h00;
                cnt_d     = cnt_eff + PW'(1);
                if (cnt_eff == CNT_LAST) begin
                    state_d = RUN;
                    cnt_d   = '0;
                end
            end
            RUN: begin
                if (clr_start) begin
                    state_d = INIT;
                    cnt_d   = '0;
                end else if (grant != 3'b000) begin
                    case (grant)
                        3'b001:  ptr_d = 2'd1;
                        3'b010:  ptr_d = 2'd2;
                        default: ptr_d = 2'd0;
                    endcase
                    if (sel_addr[PW]) begin
                        // Out-of-range: consume the request but suppress the write.
                        err_oob_d = 1'b1;
                    end else begin
                        wr_en_d   = 1'b1;
                        wr_addr_d = sel_addr;
                        wr_data_d = sel_data;
                    end
                end
            end
            default: ;
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments keep every register sampling pre-edge values, independent of statement order.
        if (reset) begin
            state_q   <= INIT;
            cnt_q     <= '0;
            ptr_q     <= 2'd0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= 8'h00;
            err_oob_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            ptr_q     <= ptr_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            err_oob_q <= err_oob_d;
        end
    end

    assign req_ready = grant;
    assign init_busy = (state_q == INIT);
    assign wr_en     = wr_en_q;
    assign wr_addr   = wr_addr_q;
    assign wr_data   = wr_data_q;
    assign err_oob   = err_oob_q;

endmodule

// File: tb/tb_reg_wr_arbiter.sv
// Directed self-checking bench for reg_wr_arbiter (PW = 4, 16 registers).
module tb_reg_wr_arbiter;

    localparam int PW = 4;

    logic                clk;
    logic                reset;
    logic [2:0]          req_valid;
    logic [3*(PW+1)-1:0] req_addr;
    logic [23:0]         req_data;
    logic [2:0]          req_ready;
    logic                clr_start;
    logic                wr_en;
    logic [PW:0]         wr_addr;
    logic [7:0]          wr_data;
    logic                init_busy;
    logic                err_oob;

    int vectors     = 0;
    int miscompares = 0;

    // Per-requester addresses and data used by the round-robin steps.
    logic [PW:0] rq_addr [3];
    logic [7:0]  rq_data [3];

    reg_wr_arbiter #(.PW(PW)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .req_ready (req_ready),
        .clr_start (clr_start),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .init_busy (init_busy),
        .err_oob   (err_oob)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop in case the sequence ever stalls.
    initial begin
        #100000;
        $display("FAIL timeout: observed no end of sequence, expected $finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge; registered outputs are then stable.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Let combinational outputs settle after an input change.
    task automatic settle();
        #1;
    endtask

    task automatic set_req(input int i, input logic [PW:0] a, input logic [7:0] d);
        req_addr[i*(PW+1) +: PW+1] = a;
        req_data[i*8 +: 8]         = d;
    endtask

    task automatic check_clear(input string tag, input int addr, input logic busy);
        check({tag, " wr_en"},   32'(wr_en),     32'd1);
        check({tag, " wr_addr"}, 32'(wr_addr),   32'(addr));
        check({tag, " wr_data"}, 32'(wr_data),   32'h0);
        check({tag, " busy"},    32'(init_busy), 32'(busy));
    endtask

    initial begin
        reset     = 1'b1;
        clr_start = 1'b0;
        req_valid = 3'b000;
        req_addr  = '0;
        req_data  = '0;
        rq_addr[0] = 5'd1; rq_data[0] = 8'h10;
        rq_addr[1] = 5'd2; rq_data[1] = 8'h21;
        rq_addr[2] = 5'd3; rq_data[2] = 8'h32;

        // Reset state.
        step();
        check("rst wr_en",   32'(wr_en),     32'd0);
        check("rst wr_addr", 32'(wr_addr),   32'd0);
        check("rst wr_data", 32'(wr_data),   32'd0);
        check("rst err_oob", 32'(err_oob),   32'd0);
        check("rst busy",    32'(init_busy), 32'd1);
        check("rst ready",   32'(req_ready), 32'd0);
        reset = 1'b0;

        // Clear sweep with requests pending: no grants during INIT.
        req_valid = 3'b111;
        for (int i = 0; i < 16; i++) begin
            step();
            if (i == 15) req_valid = 3'b000;
            settle();
            check_clear("init", i, (i < 15));
            check("init ready", 32'(req_ready), 32'd0);
        end
        step();
        check("post-init wr_en", 32'(wr_en),     32'd0);
        check("post-init busy",  32'(init_busy), 32'd0);

        // Only requester 2 valid.
        set_req(2, 5'd5, 8'hA7);
        req_valid = 3'b100;
        settle();
        check("r2 ready", 32'(req_ready), 32'b100);
        step();
        req_valid = 3'b000;
        check("r2 wr_en",   32'(wr_en),   32'd1);
        check("r2 wr_addr", 32'(wr_addr), 32'd5);
        check("r2 wr_data", 32'(wr_data), 32'hA7);
        check("r2 err_oob", 32'(err_oob), 32'd0);
        step();
        check("idle wr_en",   32'(wr_en),   32'd0);
        check("idle wr_addr", 32'(wr_addr), 32'd5);
        check("idle wr_data", 32'(wr_data), 32'hA7);

        // All three valid for six cycles: grants 0,1,2,0,1,2.
        for (int i = 0; i < 3; i++) set_req(i, rq_addr[i], rq_data[i]);
        req_valid = 3'b111;
        for (int c = 0; c < 6; c++) begin
            settle();
            check("rr ready", 32'(req_ready), 32'(3'b001 << (c % 3)));
            step();
            if (c == 5) req_valid = 3'b000;
            check("rr wr_en",   32'(wr_en),   32'd1);
            check("rr wr_addr", 32'(wr_addr), 32'(rq_addr[c % 3]));
            check("rr wr_data", 32'(wr_data), 32'(rq_data[c % 3]));
        end
        step();
        check("rr idle wr_en", 32'(wr_en), 32'd0);

        // Out-of-range address from requester 1.
        set_req(1, 5'b10011, 8'h55);
        req_valid = 3'b010;
        settle();
        check("oob ready", 32'(req_ready), 32'b010);
        step();
        req_valid = 3'b000;
        check("oob wr_en",   32'(wr_en),   32'd0);
        check("oob err",     32'(err_oob), 32'd1);
        check("oob wr_addr", 32'(wr_addr), 32'd3);
        check("oob wr_data", 32'(wr_data), 32'h32);
        step();
        check("oob err clr", 32'(err_oob), 32'd0);

        // Pointer advanced past 1 even though the write was dropped.
        set_req(1, rq_addr[1], rq_data[1]);
        req_valid = 3'b111;
        settle();
        check("ptr2 ready", 32'(req_ready), 32'b100);
        step();
        req_valid = 3'b000;
        check("ptr2 wr_addr", 32'(wr_addr), 32'd3);
        check("ptr2 wr_data", 32'(wr_data), 32'h32);

        // clr_start in RUN blocks grants and restarts the clear sweep.
        req_valid = 3'b001;
        clr_start = 1'b1;
        settle();
        check("clr ready", 32'(req_ready), 32'd0);
        step();
        clr_start = 1'b0;
        settle();
        check("clr wr_en", 32'(wr_en),     32'd0);
        check("clr busy",  32'(init_busy), 32'd1);
        for (int i = 0; i < 16; i++) begin
            step();
            check_clear("clr init", i, (i < 15));
            check("clr init ready", 32'(req_ready), (i < 15) ? 32'd0 : 32'b001);
        end
        step();
        req_valid = 3'b000;
        check("clr r0 wr_en",   32'(wr_en),   32'd1);
        check("clr r0 wr_addr", 32'(wr_addr), 32'(rq_addr[0]));
        check("clr r0 wr_data", 32'(wr_data), 32'(rq_data[0]));

        // Reset overrides a transfer in RUN.
        req_valid = 3'b010;
        reset     = 1'b1;
        step();
        req_valid = 3'b000;
        reset     = 1'b0;
        check("rstrun wr_en",   32'(wr_en),     32'd0);
        check("rstrun wr_addr", 32'(wr_addr),   32'd0);
        check("rstrun wr_data", 32'(wr_data),   32'd0);
        check("rstrun busy",    32'(init_busy), 32'd1);

        // Reset at cnt = 7 restarts the sweep from address 0.
        for (int i = 0; i < 7; i++) begin
            step();
            check_clear("pre7", i, 1'b1);
        end
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("rst7 wr_en",   32'(wr_en),     32'd0);
        check("rst7 wr_addr", 32'(wr_addr),   32'd0);
        check("rst7 busy",    32'(init_busy), 32'd1);

        // Three writes, then clr_start inside INIT restarts at address 0.
        for (int i = 0; i < 3; i++) begin
            step();
            check_clear("post7", i, 1'b1);
        end
        clr_start = 1'b1;
        step();
        clr_start = 1'b0;
        check_clear("clrinit", 0, 1'b1);
        for (int i = 1; i < 16; i++) begin
            step();
            check_clear("clrinit", i, (i < 15));
        end

        // Pointer was reset to 0: requester 0 wins over 1.
        req_valid = 3'b011;
        settle();
        check("final ready", 32'(req_ready), 32'b001);
        step();
        req_valid = 3'b000;
        check("final wr_addr", 32'(wr_addr), 32'(rq_addr[0]));
        check("final wr_data", 32'(wr_data), 32'(rq_data[0]));
        step();
        check("final idle", 32'(wr_en), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
